decode_stage: RTL and testbench

Registered RV32I decode pipeline stage that sits between fetch and execute. It accepts one instruction per cycle over a valid/ready handshake and extracts register addresses. It generates ALU op, immediate and operand-select controls, flags illegal encodings, and holds the result in a single-entry output register. It supports stall via downstream back-pressure and flush from branch or exception logic.

---
 rtl/decode_stage.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : decode_stage
// Description : Registered RV32I decode pipeline stage between fetch and
//               execute. Accepts one instruction per cycle over valid/ready,
//               decodes register addresses, ALU op, immediate and operand
//               selects, flags illegal encodings, and presents the result from
//               a single-entry output register. Supports downstream
//               back-pressure and a flush that drops held and incoming work.
// Revision    : 1.0 - initial release
// ============================================================================
// Ports:
//   clk          in   1         clock
//   rst_b        in   1         asynchronous active-low reset
//   flush        in   1         discard held and incoming instruction
//   in_valid     in   1         upstream instruction valid
//   in_ready     out  1         stage can accept this cycle
//   in_instr     in   XLEN      instruction word
//   in_pc        in   XLEN      instruction PC
//   out_valid    out  1         decoded bundle valid
//   out_ready    in   1         downstream accepts bundle
//   out_pc       out  XLEN      registered PC
//   reg_wen      out  1         write rd
//   reg_waddr    out  RF_AW     rd
//   reg_rs1_addr out  RF_AW     rs1 (0 for LUI)
//   reg_rs2_addr out  RF_AW     rs2
//   alu_op       out  ALU_OP_W  ALU operation, {func7[5], func3}
//   use_imm      out  1         operand B = imm
//   use_pc       out  1         operand A = PC
//   imm          out  XLEN      sign-extended immediate
//   mem_rd       out  1         load
//   mem_wr       out  1         store
//   ill_instr    out  1         illegal instruction
// ============================================================================
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int RF_AW    = 5,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_instr,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic                reg_wen,
  output logic [RF_AW-1:0]    reg_waddr,
  output logic [RF_AW-1:0]    reg_rs1_addr,
  output logic [RF_AW-1:0]    reg_rs2_addr,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                use_imm,
  output logic                use_pc,
  output logic [XLEN-1:0]     imm,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                ill_instr
);

  // --------------------------------------------------------------------------
  // Opcode and function-field constants
  // --------------------------------------------------------------------------
  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;

  localparam logic [6:0] c_f7_zero    = 7'b0000000;
  localparam logic [6:0] c_f7_alt     = 7'b0100000;

  localparam logic [2:0] c_f3_add_sub = 3'b000;
  localparam logic [2:0] c_f3_sll     = 3'b001;
  localparam logic [2:0] c_f3_srl_sra = 3'b101;

  // --------------------------------------------------------------------------
  // Instruction fields
  // --------------------------------------------------------------------------
  logic [6:0] w_opcode;
  logic [4:0] w_rd;
  logic [2:0] w_func3;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [6:0] w_func7;

  assign w_opcode = in_instr[6:0];
  assign w_rd     = in_instr[11:7];
  assign w_func3  = in_instr[14:12];
  assign w_rs1    = in_instr[19:15];
  assign w_rs2    = in_instr[24:20];
  assign w_func7  = in_instr[31:25];

  // Immediates: the signed casts sign-extend from instr[31] up to XLEN.
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_u;

  assign w_imm_i = XLEN'($signed(in_instr[31:20]));
  assign w_imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign w_imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic                w_reg_wen;
  logic [4:0]          w_rs1_sel;
  logic [ALU_OP_W-1:0] w_alu_op;
  logic                w_use_imm;
  logic                w_use_pc;
  logic [XLEN-1:0]     w_imm;
  logic                w_mem_rd;
  logic                w_mem_wr;
  logic                w_ill;

  always_comb begin
    w_reg_wen = 1'b0;
    w_rs1_sel = w_rs1;
    w_alu_op  = '0;
    w_use_imm = 1'b0;
    w_use_pc  = 1'b0;
    w_imm     = '0;
    w_mem_rd  = 1'b0;
    w_mem_wr  = 1'b0;
    w_ill     = 1'b0;

    case (w_opcode)
      c_opc_op: begin
        w_reg_wen = 1'b1;
        w_alu_op  = ALU_OP_W'({w_func7[5], w_func3});
        // Only SUB and SRA may use the alternate func7.
        if (w_func7 == c_f7_zero) begin
          w_ill = 1'b0;
        end else if (w_func7 == c_f7_alt &&
                     (w_func3 == c_f3_add_sub || w_func3 == c_f3_srl_sra)) begin
          w_ill = 1'b0;
        end else begin
          w_ill = 1'b1;
        end
      end

      c_opc_op_imm: begin
        w_reg_wen = 1'b1;
        w_use_imm = 1'b1;
        w_imm     = w_imm_i;
        // Bit 3 only distinguishes SRAI from SRLI; for the other immediate
        // ops the upper immediate bits are operand, not opcode.
        if (w_func3 == c_f3_srl_sra) begin
          w_alu_op = ALU_OP_W'({w_func7[5], w_func3});
          w_ill    = !(w_func7 == c_f7_zero || w_func7 == c_f7_alt);
        end else if (w_func3 == c_f3_sll) begin
          w_alu_op = ALU_OP_W'({1'b0, w_func3});
          w_ill    = (w_func7 != c_f7_zero);
        end else begin
          w_alu_op = ALU_OP_W'({1'b0, w_func3});
        end
      end

      c_opc_lui: begin
        w_reg_wen = 1'b1;
        w_use_imm = 1'b1;
        w_rs1_sel = 5'd0;
        w_imm     = w_imm_u;
      end

      c_opc_auipc: begin
        w_reg_wen = 1'b1;
        w_use_imm = 1'b1;
        w_use_pc  = 1'b1;
        w_imm     = w_imm_u;
      end

      c_opc_load: begin
        w_reg_wen = 1'b1;
        w_use_imm = 1'b1;
        w_mem_rd  = 1'b1;
        w_imm     = w_imm_i;
        // LB, LH, LW, LBU, LHU
        w_ill     = !(w_func3 == 3'b000 || w_func3 == 3'b001 ||
                      w_func3 == 3'b010 || w_func3 == 3'b100 ||
                      w_func3 == 3'b101);
      end

      c_opc_store: begin
        w_use_imm = 1'b1;
        w_mem_wr  = 1'b1;
        w_imm     = w_imm_s;
        // SB, SH, SW
        w_ill     = !(w_func3 == 3'b000 || w_func3 == 3'b001 ||
                      w_func3 == 3'b010);
      end

      default: begin
        w_ill = 1'b1;
      end
    endcase

    // An illegal instruction must have no architectural side effects; the
    // bundle still goes downstream so execute can raise the trap.
    if (w_ill) begin
      w_reg_wen = 1'b0;
      w_mem_rd  = 1'b0;
      w_mem_wr  = 1'b0;
    end

    // Writes to x0 are suppressed here so the register file needs no guard.
    if (w_rd == 5'd0) begin
      w_reg_wen = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic r_valid;
  logic w_in_ready;
  logic w_capture;

  assign w_in_ready = !r_valid || out_ready;
  assign w_capture  = in_valid && w_in_ready && !flush;

  // --------------------------------------------------------------------------
  // Output register. Data fields load only on capture so they never toggle
  // while the slot is empty or held.
  // --------------------------------------------------------------------------
  logic [XLEN-1:0]     r_pc;
  logic                r_reg_wen;
  logic [RF_AW-1:0]    r_waddr;
  logic [RF_AW-1:0]    r_rs1;
  logic [RF_AW-1:0]    r_rs2;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic                r_use_imm;
  logic                r_use_pc;
  logic [XLEN-1:0]     r_imm;
  logic                r_mem_rd;
  logic                r_mem_wr;
  logic                r_ill;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_reg_wen <= 1'b0;
      r_waddr   <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_alu_op  <= '0;
      r_use_imm <= 1'b0;
      r_use_pc  <= 1'b0;
      r_imm     <= '0;
      r_mem_rd  <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_ill     <= 1'b0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_capture) begin
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end

      if (w_capture) begin
        r_pc      <= in_pc;
        r_reg_wen <= w_reg_wen;
        r_waddr   <= RF_AW'(w_rd);
        r_rs1     <= RF_AW'(w_rs1_sel);
        r_rs2     <= RF_AW'(w_rs2);
        r_alu_op  <= w_alu_op;
        r_use_imm <= w_use_imm;
        r_use_pc  <= w_use_pc;
        r_imm     <= w_imm;
        r_mem_rd  <= w_mem_rd;
        r_mem_wr  <= w_mem_wr;
        r_ill     <= w_ill;
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = r_valid;
  assign out_pc       = r_pc;
  assign reg_wen      = r_reg_wen;
  assign reg_waddr    = r_waddr;
  assign reg_rs1_addr = r_rs1;
  assign reg_rs2_addr = r_rs2;
  assign alu_op       = r_alu_op;
  assign use_imm      = r_use_imm;
  assign use_pc       = r_use_pc;
  assign imm          = r_imm;
  assign mem_rd       = r_mem_rd;
  assign mem_wr       = r_mem_wr;
  assign ill_instr    = r_ill;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_decode_stage
// Description : Scoreboard bench for decode_stage. The driver pushes the
//               hand-computed bundle for every accepted instruction; a
//               separate monitor pops and compares on every output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  waddr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  alu;
    logic        use_imm;
    logic        use_pc;
    logic [31:0] imm;
    logic        mem_rd;
    logic        mem_wr;
    logic        ill;
  } bundle_t;

  typedef struct packed {
    logic [31:0] instr;
    bundle_t     exp;
  } vec_t;

  logic        clk;
  logic        rst_b;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic        reg_wen;
  logic [4:0]  reg_waddr;
  logic [4:0]  reg_rs1_addr;
  logic [4:0]  reg_rs2_addr;
  logic [3:0]  alu_op;
  logic        use_imm;
  logic        use_pc;
  logic [31:0] imm;
  logic        mem_rd;
  logic        mem_wr;
  logic        ill_instr;

  decode_stage #(
    .XLEN     (32),
    .RF_AW    (5),
    .ALU_OP_W (4)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .reg_wen      (reg_wen),
    .reg_waddr    (reg_waddr),
    .reg_rs1_addr (reg_rs1_addr),
    .reg_rs2_addr (reg_rs2_addr),
    .alu_op       (alu_op),
    .use_imm      (use_imm),
    .use_pc       (use_pc),
    .imm          (imm),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .ill_instr    (ill_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bundle_t act;
  assign act = {out_pc, reg_wen, reg_waddr, reg_rs1_addr, reg_rs2_addr,
                alu_op, use_imm, use_pc, imm, mem_rd, mem_wr, ill_instr};

  bundle_t sb[$];
  int      total;
  int      bad;
  vec_t    vecs[12];

  function automatic bundle_t mk(input logic [31:0] pc, input logic wen,
                                 input logic [4:0] waddr, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [3:0] alu,
                                 input logic ui, input logic up,
                                 input logic [31:0] im, input logic mr,
                                 input logic mw, input logic il);
    bundle_t b;
    b.pc = pc; b.wen = wen; b.waddr = waddr; b.rs1 = rs1; b.rs2 = rs2;
    b.alu = alu; b.use_imm = ui; b.use_pc = up; b.imm = im;
    b.mem_rd = mr; b.mem_wr = mw; b.ill = il;
    return b;
  endfunction

  task automatic check1(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic check_bundle(input string name, input bundle_t got,
                              input bundle_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Drive one instruction until accepted; the expected bundle is pushed at
  // the negedge preceding the capturing edge.
  task automatic issue(input vec_t v);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_instr = v.instr;
    in_pc    = v.exp.pc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = in_ready && !flush;
      if (acc) sb.push_back(v.exp);
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL issue_timeout instr=%h got=not_accepted want=accepted", v.instr);
    end
  endtask

  // Monitor: compare on every transfer; a flush discards the held entry.
  initial begin
    bundle_t e;
    forever begin
      @(negedge clk);
      if (rst_b && out_valid) begin
        if (flush) begin
          if (sb.size() != 0) void'(sb.pop_front());
        end else if (out_ready) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_bundle got=%h want=none", act);
          end else begin
            e = sb.pop_front();
            if (act !== e) begin
              bad++;
              $display("FAIL bundle_pc_%h got=%h want=%h", e.pc, act, e);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    //                instr          pc          wen waddr rs1 rs2 alu   ui up imm          mr mw il
    vecs[0]  = '{32'h402080B3, mk(32'h1000, 1, 1,  1,  2,  4'b1000, 0, 0, 32'h0,        0, 0, 0)}; // sub x1,x1,x2
    vecs[1]  = '{32'h40335293, mk(32'h1004, 1, 5,  6,  3,  4'b1101, 1, 0, 32'h403,      0, 0, 0)}; // srai x5,x6,3
    vecs[2]  = '{32'hFFF00093, mk(32'h1008, 1, 1,  0,  31, 4'b0000, 1, 0, 32'hFFFFFFFF, 0, 0, 0)}; // addi x1,x0,-1
    vecs[3]  = '{32'hFE000033, mk(32'h100C, 0, 0,  0,  0,  4'b1000, 0, 0, 32'h0,        0, 0, 1)}; // bad func7
    vecs[4]  = '{32'h0000007F, mk(32'h1010, 0, 0,  0,  0,  4'b0000, 0, 0, 32'h0,        0, 0, 1)}; // opcode 1111111
    vecs[5]  = '{32'h00100013, mk(32'h1014, 0, 0,  0,  1,  4'b0000, 1, 0, 32'h1,        0, 0, 0)}; // addi x0,x0,1
    vecs[6]  = '{32'h123451B7, mk(32'h1018, 1, 3,  0,  3,  4'b0000, 1, 0, 32'h12345000, 0, 0, 0)}; // lui x3
    vecs[7]  = '{32'hFFFFF217, mk(32'h101C, 1, 4,  31, 31, 4'b0000, 1, 1, 32'hFFFFF000, 0, 0, 0)}; // auipc x4
    vecs[8]  = '{32'hFFC12383, mk(32'h1020, 1, 7,  2,  28, 4'b0000, 1, 0, 32'hFFFFFFFC, 1, 0, 0)}; // lw x7,-4(x2)
    vecs[9]  = '{32'h00532423, mk(32'h1024, 0, 8,  6,  5,  4'b0000, 1, 0, 32'h8,        0, 1, 0)}; // sw x5,8(x6)
    vecs[10] = '{32'h00003083, mk(32'h1028, 0, 1,  0,  0,  4'b0000, 1, 0, 32'h0,        0, 0, 1)}; // load func3=011
    vecs[11] = '{32'h02109093, mk(32'h102C, 0, 1,  1,  1,  4'b0001, 1, 0, 32'h21,       0, 0, 1)}; // slli bad func7

    rst_b     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_pc     = 32'h0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check1("reset_out_valid", out_valid, 1'b0);
    check_bundle("reset_bundle", act, '0);
    check1("reset_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    // Streamed decode, back-to-back with downstream always ready
    for (int i = 0; i < 12; i++) issue(vecs[i]);
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure: hold vec 0 for 3 cycles while vec 1 waits
    out_ready = 1'b0;
    issue(vecs[0]);
    in_valid = 1'b1;
    in_instr = vecs[1].instr;
    in_pc    = vecs[1].exp.pc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("hold_in_ready", in_ready, 1'b0);
      check_bundle("hold_bundle", act, vecs[0].exp);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    issue(vecs[1]);
    repeat (3) @(posedge clk);
    #1;

    // Flush drops both the held bundle and the incoming instruction
    out_ready = 1'b0;
    issue(vecs[2]);
    in_valid = 1'b1;
    in_instr = vecs[6].instr;
    in_pc    = vecs[6].exp.pc;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check1("flush_out_valid", out_valid, 1'b0);
    check1("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset while a bundle is held and another is offered
    out_ready = 1'b0;
    issue(vecs[7]);
    in_valid = 1'b1;
    in_instr = vecs[8].instr;
    in_pc    = vecs[8].exp.pc;
    #2;
    rst_b = 1'b0;
    #1;
    check1("async_reset_out_valid", out_valid, 1'b0);
    check_bundle("async_reset_bundle", act, '0);
    sb.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    check1("post_reset_out_valid", out_valid, 1'b0);
    check1("post_reset_in_ready", in_ready, 1'b1);

    // Recovery after reset
    out_ready = 1'b1;
    issue(vecs[9]);
    repeat (3) @(posedge clk);
    #1;

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drained got=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
